// File: rtl/fifo_arb_pkg.sv
// Shared constants, credit type and round-robin helper for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned CRED_W         = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef logic [CRED_W-1:0] credit_t;

  // Next round-robin position after ptr, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found        = 1'b1;
        gnt[pos_idx] = 1'b1;
        gnt_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with credit-based overflow
// protection and a write-acknowledge checker.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_pop,
  output logic [$clog2(FIFO_DEPTH):0]   credits,
  output logic                          err_ack,
  output logic                          err_pop
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CRED = CW'(FIFO_DEPTH);

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d, pick_idx;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [CW-1:0]         credits_q, credits_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, ack_pend_q;
  logic                  err_ack_q, err_ack_d, err_pop_q, err_pop_d;
  logic                  wr_fire;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // No credits means no free slot once every in-flight write lands.
  assign gnt     = (rst_n && credits_q != '0) ? pick_gnt : '0;
  assign wr_fire = |gnt;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    credits_d = credits_q;
    if (wr_fire) begin
      rr_ptr_d = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
      data_d   = req_data[32'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    case ({wr_fire, fifo_pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = (credits_q == FULL_CRED) ? credits_q : credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    err_pop_d = err_pop_q | (fifo_pop && credits_q == FULL_CRED);
    // ack_pend_q marks a write the FIFO sampled last edge; its ack is due now.
    err_ack_d = err_ack_q | (ack_pend_q != fifo_wr_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      credits_q  <= FULL_CRED;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      ack_pend_q <= 1'b0;
      err_ack_q  <= 1'b0;
      err_pop_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      credits_q  <= credits_d;
      data_q     <= data_d;
      wr_en_q    <= wr_fire;
      ack_pend_q <= wr_en_q;
      err_ack_q  <= err_ack_d;
      err_pop_q  <= err_pop_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign credits      = credits_q;
  assign err_ack      = err_ack_q;
  assign err_pop      = err_pop_q;

endmodule
